// File: rtl/tms1000_pkg.sv
// Shared encodings for the nibble RAM arbiter: port operations and FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tms1000_pkg;

    // Operation requested by a port; bit ops take the bit index from wdata[1:0]
    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_SET   = 2'b10,
        OP_CLR   = 2'b11
    } op_e;

    // Arbiter FSM states; only IDLE issues grants
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        RMW  = 2'b10
    } state_e;

endpackage

// File: rtl/ram_sp.sv
// Single-port 2^ADDR_W x DATA_W RAM with synchronous, write-first read.
// Latency: rdata valid one cycle after the address edge.
// Backpressure: none; accepts one access every cycle. Contents are never reset.
module ram_sp #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Array write plus write-first registered read port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
            rdata     <= wdata;
        end else begin
            rdata     <= mem[addr];
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port (CPU, debug) arbiter onto one single-port nibble RAM; CPU has fixed priority.
// Latency: writes done at the grant edge; reads return one cycle after grant; bit ops busy for one cycle.
// Backpressure: requests are held until gnt; no grants while busy. RAM_ARB_STARVE_GUARD_EN bounds debug starvation.
module ram_arbiter
    import tms1000_pkg::*;
#(
    parameter int ADDR_W       = 6,
    parameter int DATA_W       = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [1:0]        cpu_op,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic [1:0]        dbg_op,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              busy
);

    state_e            state_q, state_d;
    op_e               req_op, op_q;
    logic              own_dbg_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        bit_q;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata, ram_q, rmw_data;
    logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;
    logic              starve_hit;

`ifdef RAM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] starve_cnt;

    // Count CPU wins while debug waits; any debug win or idle debug port clears it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (dbg_gnt || !dbg_req) begin
            starve_cnt <= '0;
        end else if (cpu_gnt) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    assign starve_hit = (starve_cnt == CNT_W'(STARVE_LIMIT));
`else
    // Guard compiled out: pure fixed priority, limit parameter has no effect
    logic [31:0] unused_starve_limit;
    assign unused_starve_limit = 32'(STARVE_LIMIT);
    assign starve_hit          = 1'b0;
`endif

    // Arbitration, RAM port steering and next-state logic
    always_comb begin
        state_d   = state_q;
        cpu_gnt   = 1'b0;
        dbg_gnt   = 1'b0;
        req_op    = OP_READ;
        ram_we    = 1'b0;
        ram_addr  = addr_q;
        ram_wdata = rmw_data;
        case (state_q)
            IDLE: begin
                if (!reset) begin
                    if (cpu_req && !(starve_hit && dbg_req)) begin
                        cpu_gnt = 1'b1;
                    end else if (dbg_req) begin
                        dbg_gnt = 1'b1;
                    end
                end
                if (cpu_gnt || dbg_gnt) begin
                    req_op    = dbg_gnt ? op_e'(dbg_op) : op_e'(cpu_op);
                    ram_addr  = dbg_gnt ? dbg_addr : cpu_addr;
                    ram_wdata = dbg_gnt ? dbg_wdata : cpu_wdata;
                    ram_we    = (req_op == OP_WRITE);
                    case (req_op)
                        OP_READ:        state_d = RD;
                        OP_SET, OP_CLR: state_d = RMW;
                        default:        state_d = IDLE;
                    endcase
                end
            end
            RD:  state_d = IDLE;
            RMW: begin
                ram_we  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Word read at the grant edge with the addressed bit forced for write-back
    always_comb begin
        rmw_data        = ram_q;
        rmw_data[bit_q] = (op_q == OP_SET);
    end

    // State register; reset drops any in-flight read or write-back
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Remember owner, op, address and bit index of the accepted access
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            own_dbg_q <= 1'b0;
            op_q      <= OP_READ;
            addr_q    <= '0;
            bit_q     <= '0;
        end else if (cpu_gnt || dbg_gnt) begin
            own_dbg_q <= dbg_gnt;
            op_q      <= req_op;
            addr_q    <= ram_addr;
            bit_q     <= ram_wdata[1:0];
        end
    end

    // Hold the last returned word per port so rdata is stable between pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            if (cpu_rvalid) cpu_rdata_q <= ram_q;
            if (dbg_rvalid) dbg_rdata_q <= ram_q;
        end
    end

    assign busy       = (state_q != IDLE);
    assign cpu_rvalid = (state_q == RD) && !own_dbg_q;
    assign dbg_rvalid = (state_q == RD) && own_dbg_q;
    assign cpu_rdata  = cpu_rvalid ? ram_q : cpu_rdata_q;
    assign dbg_rdata  = dbg_rvalid ? ram_q : dbg_rdata_q;

    ram_sp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: reset, read/write, bit ops, arbitration, starvation, reset abort.
// Inputs change 1 time unit after the rising edge; outputs are checked 2 units after it.
// Build with RAM_ARB_STARVE_GUARD_EN defined to exercise the starvation guard expectations.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_req, dbg_req;
    logic [1:0] cpu_op, dbg_op;
    logic [5:0] cpu_addr, dbg_addr;
    logic [3:0] cpu_wdata, dbg_wdata;
    logic       cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, busy;
    logic [3:0] cpu_rdata, dbg_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int gnt_cnt, busy_cnt, first_dbg, exp_first_dbg;

    always #5 clk = ~clk;

    ram_arbiter #(
        .ADDR_W       (6),
        .DATA_W       (4),
        .STARVE_LIMIT (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_op     (cpu_op),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dbg_req    (dbg_req),
        .dbg_op     (dbg_op),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_drive(input logic req, input logic [1:0] op, input logic [5:0] a, input logic [3:0] d);
        cpu_req = req; cpu_op = op; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic dbg_drive(input logic req, input logic [1:0] op, input logic [5:0] a, input logic [3:0] d);
        dbg_req = req; dbg_op = op; dbg_addr = a; dbg_wdata = d;
    endtask

    initial begin
        reset = 1'b1;
        cpu_drive(1'b0, 2'b00, 6'h00, 4'h0);
        dbg_drive(1'b0, 2'b00, 6'h00, 4'h0);
        tick(); tick();

        // Reset values, with a request pending to show grants are held off
        cpu_req = 1'b1;
        #1;
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_dbg_gnt", dbg_gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rvalid", {cpu_rvalid, dbg_rvalid}, 0);
        chk("rst_rdata", {cpu_rdata, dbg_rdata}, 0);
        tick();

        // Release reset; debug write 0x15 <= 0xA granted in the first cycle
        reset = 1'b0;
        cpu_drive(1'b0, 2'b00, 6'h00, 4'h0);
        dbg_drive(1'b1, 2'b01, 6'h15, 4'hA);
        #1;
        chk("dbg_wr_gnt", dbg_gnt, 1);
        chk("dbg_wr_cpu_gnt", cpu_gnt, 0);
        tick();
        chk("wr_no_busy", busy, 0);
        dbg_drive(1'b0, 2'b00, 6'h00, 4'h0);
        cpu_drive(1'b1, 2'b00, 6'h15, 4'h0);
        #1;
        chk("cpu_rd_gnt", cpu_gnt, 1);
        tick();
        cpu_drive(1'b0, 2'b00, 6'h00, 4'h0);
        #1;
        chk("rd_busy", busy, 1);
        chk("rd_rvalid", cpu_rvalid, 1);
        chk("rd_rdata", cpu_rdata, 4'hA);
        tick();
        chk("rd_rvalid_drop", cpu_rvalid, 0);
        chk("rd_rdata_hold", cpu_rdata, 4'hA);
        chk("rd_busy_drop", busy, 0);

        // Bit ops on 0x20 holding 0x3: set bit 2, clear bit 0, then read 0x6
        cpu_drive(1'b1, 2'b01, 6'h20, 4'h3);
        tick();
        cpu_drive(1'b1, 2'b10, 6'h20, 4'h2);
        #1;
        chk("set_gnt", cpu_gnt, 1);
        tick();
        cpu_drive(1'b1, 2'b11, 6'h20, 4'h0);
        #1;
        chk("set_busy", busy, 1);
        chk("set_rmw_no_gnt", cpu_gnt, 0);
        chk("set_no_rvalid", cpu_rvalid, 0);
        tick();
        chk("clr_gnt", cpu_gnt, 1);
        chk("clr_idle", busy, 0);
        tick();
        cpu_drive(1'b1, 2'b00, 6'h20, 4'h0);
        #1;
        chk("clr_busy", busy, 1);
        chk("clr_rmw_no_gnt", cpu_gnt, 0);
        tick();
        chk("rmw_rd_gnt", cpu_gnt, 1);
        tick();
        cpu_drive(1'b0, 2'b00, 6'h00, 4'h0);
        #1;
        chk("rmw_rd_rvalid", cpu_rvalid, 1);
        chk("rmw_rd_data", cpu_rdata, 4'h6);
        tick();

        // Simultaneous reads: CPU first, debug on the IDLE cycle after RD
        cpu_drive(1'b1, 2'b00, 6'h20, 4'h0);
        dbg_drive(1'b1, 2'b00, 6'h15, 4'h0);
        #1;
        chk("both_cpu_gnt", cpu_gnt, 1);
        chk("both_dbg_wait", dbg_gnt, 0);
        tick();
        cpu_drive(1'b0, 2'b00, 6'h00, 4'h0);
        #1;
        chk("both_rd_cpu_data", cpu_rdata, 4'h6);
        chk("both_rd_no_dbg_gnt", dbg_gnt, 0);
        tick();
        chk("both_dbg_gnt", dbg_gnt, 1);
        tick();
        dbg_drive(1'b0, 2'b00, 6'h00, 4'h0);
        #1;
        chk("both_dbg_rvalid", {dbg_rvalid, cpu_rvalid}, 2'b10);
        chk("both_dbg_data", dbg_rdata, 4'hA);
        tick();

        // Starvation: CPU writes every cycle while debug waits for a read
`ifdef RAM_ARB_STARVE_GUARD_EN
        exp_first_dbg = 9;
`else
        exp_first_dbg = 0;
`endif
        first_dbg = 0;
        dbg_drive(1'b1, 2'b00, 6'h15, 4'h0);
        for (int k = 1; k <= 12; k++) begin
            cpu_drive(1'b1, 2'b01, 6'(48 + k), 4'(k));
            #1;
            if (dbg_gnt && first_dbg == 0) first_dbg = k;
            tick();
            if (first_dbg != 0) break;
        end
        chk("starve_first_dbg_gnt", first_dbg, exp_first_dbg);
        cpu_drive(1'b0, 2'b00, 6'h00, 4'h0);
        dbg_drive(1'b0, 2'b00, 6'h00, 4'h0);
        tick(); tick();

        // Reset in the RMW cycle of set bit 3 at 0x01 holding 0x0
        cpu_drive(1'b1, 2'b01, 6'h01, 4'h0);
        tick();
        cpu_drive(1'b1, 2'b10, 6'h01, 4'h3);
        tick();
        chk("abort_in_rmw", busy, 1);
        cpu_drive(1'b0, 2'b00, 6'h00, 4'h0);
        reset = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_gnt", {cpu_gnt, dbg_gnt}, 0);
        chk("abort_rvalid", {cpu_rvalid, dbg_rvalid}, 0);
        chk("abort_rdata", {cpu_rdata, dbg_rdata}, 0);
        tick();
        chk("abort_no_rvalid", {cpu_rvalid, dbg_rvalid}, 0);
        reset = 1'b0;
        cpu_drive(1'b1, 2'b00, 6'h01, 4'h0);
        #1;
        chk("abort_first_gnt", cpu_gnt, 1);
        tick();
        cpu_drive(1'b0, 2'b00, 6'h00, 4'h0);
        #1;
        chk("abort_read_back", {cpu_rvalid, cpu_rdata}, 5'h10);
        tick();

        // Back-to-back CPU writes to every address
        gnt_cnt  = 0;
        busy_cnt = 0;
        for (int a = 0; a < 64; a++) begin
            cpu_drive(1'b1, 2'b01, 6'(a), 4'(a) ^ 4'h5);
            #1;
            if (cpu_gnt) gnt_cnt++;
            if (busy) busy_cnt++;
            tick();
        end
        chk("b2b_gnt_count", gnt_cnt, 64);
        chk("b2b_busy_count", busy_cnt, 0);
        cpu_drive(1'b1, 2'b00, 6'h3F, 4'h0);
        tick();
        cpu_drive(1'b0, 2'b00, 6'h00, 4'h0);
        #1;
        chk("b2b_read_3f", cpu_rdata, 4'hA);
        tick();
        cpu_drive(1'b1, 2'b00, 6'h00, 4'h0);
        tick();
        cpu_drive(1'b0, 2'b00, 6'h00, 4'h0);
        #1;
        chk("b2b_read_00", cpu_rdata, 4'h5);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
